// File: rtl/rbcp_reg_slave.sv
// RBCP register-file slave: maps byte-wide SiTCP RBCP accesses onto a bank
// of RW control bytes, a read-only status window, a self-clearing pulse
// byte and a constant ID byte. Every accepted access is acknowledged.
module rbcp_reg_slave #(
  parameter logic [31:0]        BASE_ADDR = 32'h0000_0000,
  parameter int                 NREG      = 16,
  parameter logic [NREG*8-1:0]  REG_INIT  = '0,
  parameter logic [7:0]         ID_VALUE  = 8'hA5
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              LOC_ACT,
  input  logic [31:0]       LOC_ADDR,
  input  logic [7:0]        LOC_WD,
  input  logic              LOC_WE,
  input  logic              LOC_RE,
  output logic              LOC_ACK,
  output logic [7:0]        LOC_RD,
  input  logic [31:0]       STATUS_IN,
  output logic [NREG*8-1:0] REG_OUT,
  output logic [7:0]        PULSE_OUT,
  output logic              WR_ERR
);

  localparam logic [4:0] OFF_STAT0 = 5'h10;
  localparam logic [4:0] OFF_STAT1 = 5'h11;
  localparam logic [4:0] OFF_STAT2 = 5'h12;
  localparam logic [4:0] OFF_STAT3 = 5'h13;
  localparam logic [4:0] OFF_PULSE = 5'h14;
  localparam logic [4:0] OFF_ID    = 5'h15;
  localparam logic [4:0] OFF_ERRCL = 5'h16;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ACK} state_t;

  state_t             state_q;
  logic               ack_q;
  logic [7:0]         rd_q;
  logic [7:0]         pulse_q;
  logic               err_q;
  logic [NREG*8-1:0]  reg_q;

  // Latched request (address, data, kind); only meaningful in EXEC
  logic [31:0]        addr_q;
  logic [7:0]         wd_q;
  logic               wr_q;

  logic               req;
  logic               hit;
  logic [4:0]         off;
  logic               reg_hit;
  logic [7:0]         rd_d;
  logic [NREG*8-1:0]  reg_d;
  logic               err_set;
  logic               err_clr;

  // A request is only taken while the bus marks the transaction active
  assign req = LOC_ACT && (LOC_WE || LOC_RE);

  // Address decode of the latched request: read data, RW-bank update, error flags
  always_comb begin
    hit     = (addr_q[31:5] == BASE_ADDR[31:5]);
    off     = addr_q[4:0];
    reg_hit = 1'b0;
    rd_d    = 8'h00;
    reg_d   = reg_q;
    if (hit) begin
      for (int k = 0; k < NREG; k++) begin
        if (off == 5'(k)) begin
          reg_hit          = 1'b1;
          rd_d             = reg_q[8*k +: 8];
          reg_d[8*k +: 8]  = wd_q;
        end
      end
      case (off)
        OFF_STAT0: rd_d = STATUS_IN[31:24];
        OFF_STAT1: rd_d = STATUS_IN[23:16];
        OFF_STAT2: rd_d = STATUS_IN[15:8];
        OFF_STAT3: rd_d = STATUS_IN[7:0];
        OFF_ID:    rd_d = ID_VALUE;
        default:   ;
      endcase
    end
    err_clr = hit && (off == OFF_ERRCL);
    err_set = !(hit && (reg_hit || off == OFF_PULSE || off == OFF_ERRCL));
  end

  // Capture the request payload when it is accepted in IDLE
  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE && req) begin
      addr_q <= LOC_ADDR;
      wd_q   <= LOC_WD;
      wr_q   <= LOC_WE;   // WE together with RE counts as a write
    end
  end

  // Access FSM IDLE -> EXEC -> ACK with all bus-facing outputs registered
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      rd_q    <= 8'h00;
      pulse_q <= 8'h00;
      err_q   <= 1'b0;
      reg_q   <= REG_INIT;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q   <= 1'b0;
          pulse_q <= 8'h00;
          if (req) state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (wr_q) begin
            reg_q <= reg_d;
            if (hit && off == OFF_PULSE) pulse_q <= wd_q;
            if (err_clr)      err_q <= 1'b0;
            else if (err_set) err_q <= 1'b1;
          end else begin
            rd_q <= rd_d;
          end
          ack_q   <= 1'b1;
          state_q <= S_ACK;
        end
        S_ACK: begin
          // Strobes seen here are dropped; the pulse lasts only this cycle
          ack_q   <= 1'b0;
          pulse_q <= 8'h00;
          state_q <= S_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          pulse_q <= 8'h00;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign LOC_ACK   = ack_q;
  assign LOC_RD    = rd_q;
  assign PULSE_OUT = pulse_q;
  assign WR_ERR    = err_q;
  assign REG_OUT   = reg_q;

endmodule

// File: tb/tb_rbcp_reg_slave.sv
// Bench for rbcp_reg_slave: directed RBCP accesses, a behavioural register
// map model checked against the DUT every cycle, plus literal spot checks.
module tb_rbcp_reg_slave;

  localparam logic [31:0]  BASE  = 32'h0000_0000;
  localparam int           NREG  = 16;
  localparam logic [127:0] RINIT = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  logic         CLK = 1'b0;
  logic         RSTn = 1'b1;
  logic         LOC_ACT = 1'b0;
  logic [31:0]  LOC_ADDR = '0;
  logic [7:0]   LOC_WD = '0;
  logic         LOC_WE = 1'b0;
  logic         LOC_RE = 1'b0;
  logic         LOC_ACK;
  logic [7:0]   LOC_RD;
  logic [31:0]  STATUS_IN = '0;
  logic [127:0] REG_OUT;
  logic [7:0]   PULSE_OUT;
  logic         WR_ERR;

  rbcp_reg_slave #(
    .BASE_ADDR(BASE), .NREG(NREG), .REG_INIT(RINIT), .ID_VALUE(8'hA5)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .LOC_ACT(LOC_ACT), .LOC_ADDR(LOC_ADDR),
    .LOC_WD(LOC_WD), .LOC_WE(LOC_WE), .LOC_RE(LOC_RE), .LOC_ACK(LOC_ACK),
    .LOC_RD(LOC_RD), .STATUS_IN(STATUS_IN), .REG_OUT(REG_OUT),
    .PULSE_OUT(PULSE_OUT), .WR_ERR(WR_ERR)
  );

  always #5 CLK = ~CLK;

  // Behavioural model state
  logic [7:0] mreg [NREG];
  logic       exp_ack;
  logic [7:0] exp_rd;
  logic [7:0] exp_pulse;
  logic       exp_err;
  bit         run_chk = 1'b0;
  int         nvec = 0;
  int         nmis = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [127:0] mbank();
    logic [127:0] b;
    for (int k = 0; k < NREG; k++) b[8*k +: 8] = mreg[k];
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) mreg[k] = RINIT[8*k +: 8];
    exp_ack = 1'b0; exp_rd = 8'h00; exp_pulse = 8'h00; exp_err = 1'b0;
  endtask

  function automatic logic [7:0] mread(input logic [31:0] a);
    int off;
    if (a[31:5] != BASE[31:5]) return 8'h00;
    off = int'(a[4:0]);
    if (off < NREG) return mreg[off];
    case (off)
      16: return STATUS_IN[31:24];
      17: return STATUS_IN[23:16];
      18: return STATUS_IN[15:8];
      19: return STATUS_IN[7:0];
      21: return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  task automatic mwrite(input logic [31:0] a, input logic [7:0] d);
    int off;
    off = int'(a[4:0]);
    if (a[31:5] != BASE[31:5]) exp_err = 1'b1;
    else if (off < NREG)       mreg[off] = d;
    else if (off == 20)        exp_pulse = d;
    else if (off == 22)        exp_err = 1'b0;
    else                       exp_err = 1'b1;
  endtask

  // Every-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(negedge CLK);
      if (run_chk) begin
        chk("LOC_ACK",   LOC_ACK,   exp_ack);
        chk("LOC_RD",    LOC_RD,    exp_rd);
        chk("PULSE_OUT", PULSE_OUT, exp_pulse);
        chk("WR_ERR",    WR_ERR,    exp_err);
        chk("REG_OUT",   REG_OUT,   mbank());
      end
    end
  end

  // One RBCP access, entered and left at posedge+1. Optional second strobe
  // during EXEC (dup). Returns the outputs seen in the ACK cycle (n+2).
  task automatic access(input bit we, input bit re, input bit act,
                        input logic [31:0] a, input logic [7:0] d, input bit dup,
                        output logic ack, output logic [7:0] rd, output logic [7:0] pls);
    LOC_ACT = act; LOC_ADDR = a; LOC_WD = d; LOC_WE = we; LOC_RE = re;
    @(posedge CLK); #1;
    if (dup) begin
      LOC_ACT = 1'b1; LOC_WE = 1'b1; LOC_ADDR = a + 32'd1; LOC_WD = ~d;
    end else begin
      LOC_ACT = 1'b0; LOC_WE = 1'b0; LOC_RE = 1'b0;
    end
    @(posedge CLK); #1;
    LOC_ACT = 1'b0; LOC_WE = 1'b0; LOC_RE = 1'b0;
    if (act && (we || re)) begin
      exp_ack = 1'b1;
      if (we) mwrite(a, d);
      else    exp_rd = mread(a);
    end
    ack = LOC_ACK; rd = LOC_RD; pls = PULSE_OUT;
    @(posedge CLK); #1;
    exp_ack = 1'b0; exp_pulse = 8'h00;
  endtask

  task automatic rd_lit(input string name, input logic [31:0] a, input logic [7:0] want);
    logic ack; logic [7:0] rd; logic [7:0] pls;
    access(1'b0, 1'b1, 1'b1, a, 8'h00, 1'b0, ack, rd, pls);
    chk({name, "_ack"}, ack, 1'b1);
    chk(name, rd, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic ack; logic [7:0] rd; logic [7:0] pls;
    logic [7:0] stat_exp [4];
    stat_exp[0] = 8'h12; stat_exp[1] = 8'h34; stat_exp[2] = 8'h56; stat_exp[3] = 8'h78;

    #1 RSTn = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ack", LOC_ACK, 1'b0);
    chk("rst_rd", LOC_RD, 8'h00);
    chk("rst_reg", REG_OUT, RINIT);
    RSTn = 1'b1;
    run_chk = 1'b1;

    // Default reads: offset 0 and the ID byte
    rd_lit("rd_off0", BASE + 32'h00, 8'h00);
    rd_lit("rd_id",   BASE + 32'h15, 8'hA5);

    // RW register write and readback
    access(1'b1, 1'b0, 1'b1, BASE + 32'h03, 8'h3C, 1'b0, ack, rd, pls);
    chk("wr03_ack", ack, 1'b1);
    chk("wr03_reg", REG_OUT[31:24], 8'h3C);
    rd_lit("rd_off3", BASE + 32'h03, 8'h3C);
    chk("wr03_err", WR_ERR, 1'b0);

    // Status window, MSB first
    STATUS_IN = 32'h1234_5678;
    for (int i = 0; i < 4; i++) rd_lit("rd_stat", BASE + 32'h10 + 32'(i), stat_exp[i]);

    // Pulse register
    access(1'b1, 1'b0, 1'b1, BASE + 32'h14, 8'h81, 1'b0, ack, rd, pls);
    chk("pulse_val", pls, 8'h81);
    chk("pulse_after", PULSE_OUT, 8'h00);
    rd_lit("rd_pulse", BASE + 32'h14, 8'h00);

    // Unmapped / off-window writes set the sticky error
    access(1'b1, 1'b0, 1'b1, BASE + 32'h1F, 8'hEE, 1'b0, ack, rd, pls);
    chk("wr1f_ack", ack, 1'b1);
    chk("wr1f_err", WR_ERR, 1'b1);
    access(1'b1, 1'b0, 1'b1, 32'h0000_0100, 8'hEE, 1'b0, ack, rd, pls);
    chk("wr100_ack", ack, 1'b1);
    chk("wr100_reg", REG_OUT, 128'h0F0E0D0C_0B0A0908_07060504_3C020100);
    chk("wr100_err", WR_ERR, 1'b1);
    access(1'b1, 1'b0, 1'b1, BASE + 32'h16, 8'h5A, 1'b0, ack, rd, pls);
    chk("errclr", WR_ERR, 1'b0);

    // WE+RE together is a write; a second strobe in EXEC is dropped
    access(1'b1, 1'b1, 1'b1, BASE + 32'h05, 8'h77, 1'b1, ack, rd, pls);
    chk("wewr_ack", ack, 1'b1);
    chk("wewr_b5", REG_OUT[47:40], 8'h77);
    chk("wewr_b6", REG_OUT[55:48], 8'h06);
    chk("wewr_rd", rd, 8'h00);

    // Strobe without LOC_ACT is ignored
    access(1'b1, 1'b0, 1'b0, BASE + 32'h07, 8'hFF, 1'b0, ack, rd, pls);
    chk("noact_ack", ack, 1'b0);
    chk("noact_b7", REG_OUT[63:56], 8'h07);

    rd_lit("rd_off5", BASE + 32'h05, 8'h77);

    // Reset during EXEC aborts the access
    LOC_ACT = 1'b1; LOC_ADDR = BASE + 32'h02; LOC_WD = 8'hAB; LOC_WE = 1'b1;
    @(posedge CLK); #1;
    LOC_ACT = 1'b0; LOC_WE = 1'b0;
    #2 RSTn = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rstx_reg", REG_OUT, RINIT);
    chk("rstx_rd", LOC_RD, 8'h00);
    chk("rstx_ack", LOC_ACK, 1'b0);
    rd_lit("rd_after_rst", BASE + 32'h02, 8'h02);

    run_chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
